// File: rtl/datapath_pkg.sv
// datapath_pkg
// Shared constants for the datapath register file and the alu32 that
// consumes its operands: default widths, the hardwired-zero register
// address and the bit positions of the V/N/Z status flags.
package datapath_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Address of the register that always reads as zero.
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  // Status flag bit positions, shared with alu32.
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/datapath_regfile_if.sv
// datapath_regfile_if
// Bundles the read ports, the writeback port and the flag-capture port of
// the register file.
//   master : operand/writeback producer (drives addresses, write data, flag inputs)
//   slave  : the register file (drives read data and the registered flags)
// Signals:
//   rs1_addr/rs2_addr  read addresses        rs1_data/rs2_data  read data (to alu32 op1/op2)
//   wr_en/wr_addr/wr_data  writeback port    flag_we, v_in/n_in/z_in  flag capture
//   v_flag/n_flag/z_flag   registered status flags
interface datapath_regfile_if
  import datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              flag_we;
  logic              v_in;
  logic              n_in;
  logic              z_in;
  logic              v_flag;
  logic              n_flag;
  logic              z_flag;

  modport master (
    output rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, flag_we, v_in, n_in, z_in,
    input  rs1_data, rs2_data, v_flag, n_flag, z_flag
  );

  modport slave (
    input  rs1_addr, rs2_addr, wr_en, wr_addr, wr_data, flag_we, v_in, n_in, z_in,
    output rs1_data, rs2_data, v_flag, n_flag, z_flag
  );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read port: selects the addressed register, forces the
// zero register to 0 and, when BYPASS is set, forwards same-cycle write data.
// Ports:
//   rd_addr   in   read address
//   regs      in   whole storage array
//   wr_en/wr_addr/wr_data  in  writeback port, used for forwarding
//   rd_data   out  read data
module regfile_read_port
  import datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0]                  rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam bit                BYP_EN    = (BYPASS != 32'sd0);

  logic hit_s;

  // Forwarding hit: a live, non-discarded write to the address being read.
  always_comb begin
    hit_s = 1'b0;
    if (BYP_EN && wr_en && (wr_addr != ZERO_ADDR) && (wr_addr == rd_addr)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Read mux: zero register first, then forwarded data, then storage.
  always_comb begin
    rd_data = {DATA_W{1'b0}};
    if (rd_addr == ZERO_ADDR) begin
      rd_data = {DATA_W{1'b0}};
    end else if (hit_s) begin
      rd_data = wr_data;
    end else begin
      rd_data = regs[rd_addr];
    end
  end

endmodule

// File: rtl/datapath_regfile.sv
// datapath_regfile
// 2**ADDR_W x DATA_W register file with two combinational read ports, one
// synchronous write port and a 3-bit V/N/Z status-flag register captured
// from alu32. Register 0 is hardwired to zero.
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   rst_n  in  asynchronous active-low reset; clears registers and flags
//   bus    slave side of datapath_regfile_if (read/write/flag ports)
module datapath_regfile
  import datapath_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input logic               clk,
  input logic               rst_n,
  datapath_regfile_if.slave bus
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0][DATA_W-1:0] regs_r;
  logic [FLAG_W-1:0]            flags_r;
  logic [DATA_W-1:0]            rs1_data_s;
  logic [DATA_W-1:0]            rs2_data_s;

  // Register storage; writes to the zero register are dropped so entry 0 stays cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_r <= {(DEPTH*DATA_W){1'b0}};
    end else if (bus.wr_en && (bus.wr_addr != ZERO_ADDR)) begin
      regs_r[bus.wr_addr] <= bus.wr_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Status flag capture; flags only reach outputs through this register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 3'b000;
    end else if (bus.flag_we) begin
      flags_r[FLAG_V] <= bus.v_in;
      flags_r[FLAG_N] <= bus.n_in;
      flags_r[FLAG_Z] <= bus.z_in;
    end else begin
      flags_r <= flags_r;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd1 (
    .rd_addr (bus.rs1_addr),
    .regs    (regs_r),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_data (rs1_data_s)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd2 (
    .rd_addr (bus.rs2_addr),
    .regs    (regs_r),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_data (rs2_data_s)
  );

  assign bus.rs1_data = rs1_data_s;
  assign bus.rs2_data = rs2_data_s;
  assign bus.v_flag   = flags_r[FLAG_V];
  assign bus.n_flag   = flags_r[FLAG_N];
  assign bus.z_flag   = flags_r[FLAG_Z];

endmodule

// File: tb/tb_datapath_regfile.sv
// tb_datapath_regfile
// Drives a bypassing and a non-bypassing register file with identical
// stimulus. The stimulus process pushes the expected pre-edge view (read data
// for both variants and the flags) into a scoreboard queue; a monitor pops
// and compares once per cycle, mid-way between rising edges.
module tb_datapath_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  datapath_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
  datapath_regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nb ();

  datapath_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  datapath_regfile #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) dut_nb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nb)
  );

  // Reference model: plain array of register contents and a {v,n,z} vector.
  logic [31:0] mregs [32];
  logic [2:0]  mflags;

  // Current stimulus, visible to the model read function.
  logic [4:0]  s_rs1, s_rs2, s_waddr;
  logic        s_wen, s_fwe;
  logic [31:0] s_wdata;
  logic [2:0]  s_fin;

  typedef struct packed {
    logic [31:0] r1_b;
    logic [31:0] r2_b;
    logic [31:0] r1_nb;
    logic [31:0] r2_nb;
    logic [2:0]  fl;
    logic [15:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;

  // What a read of address a should show right now, with or without forwarding.
  function automatic logic [31:0] model_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && s_wen && (s_waddr != 5'd0) && (s_waddr == a)) return s_wdata;
    return mregs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mflags = 3'b000;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input int id);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, push the expectation,
  // then advance the model to the state after the coming rising edge.
  task automatic step(input logic rstv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                      input logic fwe, input logic [2:0] fin);
    exp_t e;
    @(negedge clk);
    rst_n = rstv;
    s_rs1 = rs1; s_rs2 = rs2; s_wen = wen; s_waddr = waddr; s_wdata = wdata;
    s_fwe = fwe; s_fin = fin;
    bus_b.rs1_addr  = rs1;   bus_nb.rs1_addr = rs1;
    bus_b.rs2_addr  = rs2;   bus_nb.rs2_addr = rs2;
    bus_b.wr_en     = wen;   bus_nb.wr_en    = wen;
    bus_b.wr_addr   = waddr; bus_nb.wr_addr  = waddr;
    bus_b.wr_data   = wdata; bus_nb.wr_data  = wdata;
    bus_b.flag_we   = fwe;   bus_nb.flag_we  = fwe;
    bus_b.v_in = fin[2]; bus_b.n_in = fin[1]; bus_b.z_in = fin[0];
    bus_nb.v_in = fin[2]; bus_nb.n_in = fin[1]; bus_nb.z_in = fin[0];
    if (!rstv) model_clear();
    e.r1_b  = model_read(rs1, 1'b1);
    e.r2_b  = model_read(rs2, 1'b1);
    e.r1_nb = model_read(rs1, 1'b0);
    e.r2_nb = model_read(rs2, 1'b0);
    e.fl    = mflags;
    e.id    = 16'(step_id);
    sb_q.push_back(e);
    step_id++;
    if (rstv) begin
      if (wen && (waddr != 5'd0)) mregs[waddr] = wdata;
      if (fwe) mflags = fin;
    end
  endtask

  // Monitor: compare the settled outputs of both DUTs against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rs1_bypass",   bus_b.rs1_data,  e.r1_b,  int'(e.id));
        chk("rs2_bypass",   bus_b.rs2_data,  e.r2_b,  int'(e.id));
        chk("rs1_nobypass", bus_nb.rs1_data, e.r1_nb, int'(e.id));
        chk("rs2_nobypass", bus_nb.rs2_data, e.r2_nb, int'(e.id));
        chk("flags_bypass",   {29'd0, bus_b.v_flag,  bus_b.n_flag,  bus_b.z_flag},  {29'd0, e.fl}, int'(e.id));
        chk("flags_nobypass", {29'd0, bus_nb.v_flag, bus_nb.n_flag, bus_nb.z_flag}, {29'd0, e.fl}, int'(e.id));
      end
    end
  end

  initial begin
    logic [4:0]  r1, r2, wa;
    logic [31:0] wd;
    rst_n = 1'b0;
    model_clear();
    s_rs1 = 5'd0; s_rs2 = 5'd0; s_wen = 1'b0; s_waddr = 5'd0; s_wdata = 32'h0;
    s_fwe = 1'b0; s_fin = 3'b000;

    // Reset: every register reads zero on both ports, flags zero.
    for (int i = 0; i < 16; i++)
      step(1'b0, 5'(2*i), 5'(2*i+1), 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
    // Leave reset; contents still zero.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'(i), 5'(31-i), 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);

    // Two writes, then read them back as ALU operands.
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd3, 32'h000000FF, 1'b0, 3'b000);
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 32'h00000F0F, 1'b0, 3'b000);
    step(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 3'b000);

    // Write to r0 is discarded and never forwarded.
    step(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 3'b000);
    step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 3'b000);

    // Same-cycle write/read of r5 on both ports, then the stored value.
    step(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hFFFFFFF6, 1'b0, 3'b000);
    step(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 3'b000);

    // Flag capture, then hold with different inputs.
    step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0, 1'b1, 3'b010);
    step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 3'b101);
    step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 3'b111);

    // Write and flag capture in the same cycle.
    step(1'b1, 5'd11, 5'd12, 1'b1, 5'd11, 32'hA5A5A5A5, 1'b1, 3'b111);
    step(1'b1, 5'd11, 5'd12, 1'b0, 5'd0,  32'h0,        1'b0, 3'b000);

    // r9 written, then reset asserted between edges clears it at once.
    step(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 32'h12345678, 1'b0, 3'b000);
    step(1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        1'b1, 3'b101);
    step(1'b0, 5'd9, 5'd3, 1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 3'b111);
    // First rising edge after release already takes a write and a flag capture.
    step(1'b1, 5'd4, 5'd9, 1'b1, 5'd6, 32'h600DD00D, 1'b1, 3'b001);
    step(1'b1, 5'd6, 5'd4, 1'b0, 5'd0, 32'h0,        1'b0, 3'b000);

    // Randomised traffic, biased towards reading the address being written.
    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      wd = $urandom;
      step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1, r1, r2,
           1'($urandom_range(0, 1)), wa, wd,
           1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
